// File: rtl/calc2_req_scheduler.sv
// calc2 request front-end: captures two-cycle requests from four ports, round-robin
// issues them to the shared ALU and steers each ALU result back to its port.
module calc2_req_scheduler #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int NPORT  = 4
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [4*NPORT-1:0]       req_cmd_in,
    input  logic [DATA_W*NPORT-1:0]  req_data_in,
    input  logic [TAG_W*NPORT-1:0]   req_tag_in,
    output logic                     alu_issue,
    output logic [3:0]               alu_cmd,
    output logic [DATA_W-1:0]        alu_op1,
    output logic [DATA_W-1:0]        alu_op2,
    output logic [1:0]               alu_port,
    input  logic                     alu_rsp_valid,
    input  logic [1:0]               alu_rsp_port,
    input  logic [DATA_W-1:0]        alu_rsp_data,
    input  logic                     alu_rsp_err,
    output logic [2*NPORT-1:0]       out_resp,
    output logic [DATA_W*NPORT-1:0]  out_data,
    output logic [TAG_W*NPORT-1:0]   out_tag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP2,
        S_PEND,
        S_INV,
        S_BUSY,
        S_RESP
    } port_state_t;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    port_state_t       state_q [NPORT];
    port_state_t       state_d [NPORT];
    logic [3:0]        cmd_q   [NPORT];
    logic [DATA_W-1:0] op1_q   [NPORT];
    logic [DATA_W-1:0] op2_q   [NPORT];
    logic [TAG_W-1:0]  tag_q   [NPORT];

    logic [1:0]        rr_ptr;
    logic [NPORT-1:0]  elig;
    logic [NPORT-1:0]  rsp_hit;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [DATA_W-1:0] gnt_op2;

    function automatic logic cmd_valid(input logic [3:0] c);
        case (c)
            4'd1, 4'd2, 4'd5, 4'd6: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // A port in OP2 with a valid cmd already competes, so a grant on that edge
    // issues the cycle right after PEND would be entered and skips straight to BUSY.
    always_comb begin
        elig    = '0;
        rsp_hit = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            elig[p] = (state_q[p] == S_PEND) ||
                      ((state_q[p] == S_OP2) && cmd_valid(cmd_q[p]));
            rsp_hit[p] = alu_rsp_valid && (alu_rsp_port == 2'(p)) &&
                         (state_q[p] == S_BUSY);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            cand = rr_ptr + 2'(i);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_op2 = (state_q[gnt_idx] == S_OP2)
                ? req_data_in[int'(gnt_idx)*DATA_W +: DATA_W]
                : op2_q[gnt_idx];
    end

    always_comb begin
        for (int unsigned p = 0; p < NPORT; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                S_IDLE: if (req_cmd_in[p*4 +: 4] != 4'd0) state_d[p] = S_OP2;
                S_OP2: begin
                    if (!cmd_valid(cmd_q[p]))
                        state_d[p] = S_INV;
                    else if (gnt_any && (gnt_idx == 2'(p)))
                        state_d[p] = S_BUSY;
                    else
                        state_d[p] = S_PEND;
                end
                S_PEND: if (gnt_any && (gnt_idx == 2'(p))) state_d[p] = S_BUSY;
                S_INV:  state_d[p] = S_IDLE;
                S_BUSY: if (rsp_hit[p]) state_d[p] = S_RESP;
                S_RESP: state_d[p] = S_IDLE;
                default: state_d[p] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (reset) state_q[p] <= S_IDLE;
            else       state_q[p] <= state_d[p];
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            alu_issue <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_port  <= '0;
            rr_ptr    <= '0;
        end else begin
            alu_issue <= gnt_any;
            if (gnt_any) begin
                alu_cmd  <= cmd_q[gnt_idx];
                alu_op1  <= op1_q[gnt_idx];
                alu_op2  <= gnt_op2;
                alu_port <= gnt_idx;
                rr_ptr   <= gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (reset) begin
                cmd_q[p]                    <= '0;
                op1_q[p]                    <= '0;
                op2_q[p]                    <= '0;
                tag_q[p]                    <= '0;
                out_resp[p*2 +: 2]          <= '0;
                out_data[p*DATA_W +: DATA_W] <= '0;
                out_tag[p*TAG_W +: TAG_W]   <= '0;
            end else begin
                if ((state_q[p] == S_IDLE) && (req_cmd_in[p*4 +: 4] != 4'd0)) begin
                    cmd_q[p] <= req_cmd_in[p*4 +: 4];
                    op1_q[p] <= req_data_in[p*DATA_W +: DATA_W];
                    tag_q[p] <= req_tag_in[p*TAG_W +: TAG_W];
                end
                if (state_q[p] == S_OP2)
                    op2_q[p] <= req_data_in[p*DATA_W +: DATA_W];

                out_resp[p*2 +: 2]           <= '0;
                out_data[p*DATA_W +: DATA_W] <= '0;
                out_tag[p*TAG_W +: TAG_W]    <= '0;
                if ((state_q[p] == S_OP2) && !cmd_valid(cmd_q[p])) begin
                    out_resp[p*2 +: 2]        <= RESP_ERR;
                    out_tag[p*TAG_W +: TAG_W] <= tag_q[p];
                end else if (rsp_hit[p]) begin
                    out_resp[p*2 +: 2]           <= alu_rsp_err ? RESP_ERR : RESP_OK;
                    out_data[p*DATA_W +: DATA_W] <= alu_rsp_data;
                    out_tag[p*TAG_W +: TAG_W]    <= tag_q[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_calc2_req_scheduler.sv
// Scoreboard bench for calc2_req_scheduler with a two-stage ALU model.
module tb_calc2_req_scheduler;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int NP = 4;

    logic              c_clk = 1'b0;
    logic              reset;
    logic [4*NP-1:0]   req_cmd_in;
    logic [DW*NP-1:0]  req_data_in;
    logic [TW*NP-1:0]  req_tag_in;
    logic              alu_issue;
    logic [3:0]        alu_cmd;
    logic [DW-1:0]     alu_op1;
    logic [DW-1:0]     alu_op2;
    logic [1:0]        alu_port;
    logic              alu_rsp_valid = 1'b0;
    logic [1:0]        alu_rsp_port  = '0;
    logic [DW-1:0]     alu_rsp_data  = '0;
    logic              alu_rsp_err   = 1'b0;
    logic [2*NP-1:0]   out_resp;
    logic [DW*NP-1:0]  out_data;
    logic [TW*NP-1:0]  out_tag;

    calc2_req_scheduler #(.DATA_W(DW), .TAG_W(TW), .NPORT(NP)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .alu_issue(alu_issue), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_port(alu_port),
        .alu_rsp_valid(alu_rsp_valid), .alu_rsp_port(alu_rsp_port),
        .alu_rsp_data(alu_rsp_data), .alu_rsp_err(alu_rsp_err),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  port;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          cyc;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[NP][$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [32:0] alu_calc(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (cmd)
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {a < b, a - b};
            4'd5:    return {1'b0, a << sh};
            4'd6:    return {1'b0, a >> sh};
            default: return '0;
        endcase
    endfunction

    // ALU: result returned one cycle after the issue cycle
    logic        s1_v = 1'b0;
    logic [1:0]  s1_p = '0;
    logic [32:0] s1_r = '0;
    always @(negedge c_clk) begin
        alu_rsp_valid = s1_v;
        alu_rsp_port  = s1_p;
        {alu_rsp_err, alu_rsp_data} = s1_r;
        s1_v = alu_issue;
        s1_p = alu_port;
        s1_r = alu_calc(alu_cmd, alu_op1, alu_op2);
    end

    always @(negedge c_clk) begin
        iss_t e;
        rsp_t r;
        logic [1:0] got;
        if (alu_issue === 1'b1) begin
            if (iss_q.size() == 0) begin
                check("issue_unexpected", alu_issue, 0);
            end else begin
                e = iss_q.pop_front();
                check("issue_cmd",  alu_cmd,  e.cmd);
                check("issue_op1",  alu_op1,  e.op1);
                check("issue_op2",  alu_op2,  e.op2);
                check("issue_port", alu_port, e.port);
                check("issue_cyc",  cyc,      e.cyc);
            end
        end
        for (int p = 0; p < NP; p++) begin
            got = out_resp[p*2 +: 2];
            if (got != 2'd0) begin
                if (rsp_q[p].size() == 0) begin
                    check($sformatf("resp_unexpected_p%0d", p), got, 0);
                end else begin
                    r = rsp_q[p].pop_front();
                    check($sformatf("resp_code_p%0d", p), got, r.resp);
                    check($sformatf("resp_data_p%0d", p), out_data[p*DW +: DW], r.data);
                    check($sformatf("resp_tag_p%0d", p),  out_tag[p*TW +: TW], r.tag);
                    check($sformatf("resp_cyc_p%0d", p),  cyc, r.cyc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] d,
                            input logic [1:0] tag);
        req_cmd_in[p*4 +: 4]   = cmd;
        req_data_in[p*DW +: DW] = d;
        req_tag_in[p*TW +: TW]  = tag;
    endtask

    task automatic expect_req(input int p, input logic [3:0] cmd, input logic [31:0] a,
                              input logic [31:0] b, input logic [1:0] tag,
                              input int c0, input int icyc);
        iss_t e;
        rsp_t r;
        logic [32:0] res;
        if (cmd inside {4'd1, 4'd2, 4'd5, 4'd6}) begin
            e = '{cmd, a, b, 2'(p), icyc};
            iss_q.push_back(e);
            res = alu_calc(cmd, a, b);
            r = '{(res[32] ? 2'd2 : 2'd1), res[31:0], tag, icyc + 2};
        end else begin
            r = '{2'd2, 32'd0, tag, c0 + 2};
        end
        rsp_q[p].push_back(r);
    endtask

    task automatic req1(input int p, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] tag);
        int c0;
        c0 = cyc;
        set_port(p, cmd, a, tag);
        expect_req(p, cmd, a, b, tag, c0, c0 + 2);
        next_cycle();
        set_port(p, 4'd0, b, 2'd0);
        next_cycle();
        set_port(p, 4'd0, 32'd0, 2'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_issue"}, alu_issue, 0);
        check({tag, "_cmd"},   alu_cmd,   0);
        check({tag, "_op1"},   alu_op1,   0);
        check({tag, "_op2"},   alu_op2,   0);
        check({tag, "_port"},  alu_port,  0);
        check({tag, "_resp"},  out_resp,  0);
        check({tag, "_data"},  out_data[63:0], 0);
        check({tag, "_tag"},   out_tag,   0);
    endtask

    logic [3:0]  r2_cmd [NP] = '{4'd5, 4'd6, 4'd1, 4'd2};
    logic [31:0] r_a    [NP] = '{32'h0000_0300, 32'h8000_0000, 32'h1234_0000, 32'h0000_0010};
    logic [31:0] r_b    [NP] = '{32'h0000_0004, 32'h0000_001F, 32'h0000_5678, 32'h0000_0020};

    initial begin
        int c0;
        reset       = 1'b1;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        check_all_zero("reset");
        @(posedge c_clk);
        #1 reset = 1'b0;
        next_cycle();

        // all four ports sub at once, then again straight after wrap with mixed ops
        c0 = cyc;
        for (int p = 0; p < NP; p++) begin
            set_port(p, 4'd2, r_a[p] + 32'h100, 2'(p));
            expect_req(p, 4'd2, r_a[p] + 32'h100, r_b[p], 2'(p), c0, c0 + 2 + p);
        end
        next_cycle();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, r_b[p], 2'd0);
        next_cycle();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd0, 2'd0);
        repeat (6) next_cycle();
        c0 = cyc;
        for (int p = 0; p < NP; p++) begin
            set_port(p, r2_cmd[p], r_a[p], 2'(3 - p));
            expect_req(p, r2_cmd[p], r_a[p], r_b[p], 2'(3 - p), c0, c0 + 2 + p);
        end
        next_cycle();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, r_b[p], 2'd0);
        next_cycle();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd0, 2'd0);
        repeat (8) next_cycle();

        req1(0, 4'd1, 32'h30, 32'h20, 2'd1);
        repeat (6) next_cycle();
        req1(2, 4'd3, 32'h1234, 32'h5678, 2'd2);
        repeat (4) next_cycle();
        req1(3, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd3);
        repeat (6) next_cycle();

        // reset while port1 is BUSY; the late ALU result must be dropped
        c0 = cyc;
        set_port(1, 4'd1, 32'h5, 2'd2);
        iss_q.push_back('{4'd1, 32'h5, 32'h7, 2'd1, c0 + 2});
        next_cycle();
        set_port(1, 4'd0, 32'h7, 2'd0);
        next_cycle();
        set_port(1, 4'd0, 32'd0, 2'd0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge c_clk);
        check_all_zero("midreset");
        repeat (5) next_cycle();

        // port0 drives a new cmd while BUSY; it must be ignored
        c0 = cyc;
        set_port(0, 4'd1, 32'h11, 2'd2);
        expect_req(0, 4'd1, 32'h11, 32'h22, 2'd2, c0, c0 + 2);
        next_cycle();
        set_port(0, 4'd0, 32'h22, 2'd0);
        next_cycle();
        set_port(0, 4'd5, 32'hAAAA, 2'd3);
        next_cycle();
        next_cycle();
        set_port(0, 4'd0, 32'd0, 2'd0);
        repeat (6) next_cycle();

        check("issue_queue_left", iss_q.size(), 0);
        for (int p = 0; p < NP; p++)
            check($sformatf("resp_queue_left_p%0d", p), rsp_q[p].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
